// File: rtl/lock_pkg.sv
// Shared state type and constants for the lock-on controller.
// The centre-window helper is shared so every user applies the same inclusive bounds.
package lock_pkg;

  typedef enum logic [1:0] {
    StUnlocked,
    StSearch,
    StLocked,
    StLost
  } lock_state_e;

  localparam int unsigned NTgtDefault = 16;

  localparam logic [9:0] CenterXMin = 10'd288;
  localparam logic [9:0] CenterXMax = 10'd351;
  localparam logic [9:0] CenterYMin = 10'd208;
  localparam logic [9:0] CenterYMax = 10'd271;

  function automatic logic in_center(input logic [9:0] x, input logic [9:0] y);
    return (x >= CenterXMin) && (x <= CenterXMax) && (y >= CenterYMin) && (y <= CenterYMax);
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a level input.
// The previous level is registered; rise is high in the cycle the level first reads 1.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/lock_on_ctrl.sv
// Target lock-on controller: a left click scans all slots for a box under the cursor and
// locks the lowest-index match; the lock survives short detection dropouts.
module lock_on_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned N_TGT       = NTgtDefault,
  parameter int unsigned LOST_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [N_TGT*10-1:0] aim_x_all,
  input  logic [N_TGT*10-1:0] aim_y_all,
  input  logic [N_TGT-1:0]    aim_detected_all,
  input  logic [N_TGT*12-1:0] box_x_min_all,
  input  logic [N_TGT*12-1:0] box_x_max_all,
  input  logic [N_TGT*12-1:0] box_y_min_all,
  input  logic [N_TGT*12-1:0] box_y_max_all,
  input  logic [9:0]          mouse_x_pixel,
  input  logic [9:0]          mouse_y_pixel,
  input  logic                click_l,
  input  logic                click_r,
  input  logic                target_off,
  output logic                is_locked,
  output logic [3:0]          locked_idx,
  output logic                center_hit,
  output logic                lock_event,
  output logic                lost_event,
  output logic                busy
);

  localparam int unsigned CntW    = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;
  localparam logic [3:0]  LastIdx = 4'(N_TGT - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(LOST_FRAMES - 1);

  lock_state_e     state_q;
  logic [3:0]      scan_q;
  logic            found_q;
  logic [3:0]      cand_q;
  logic [CntW-1:0] lost_cnt_q;
  logic [9:0]      mouse_x_q;
  logic [9:0]      mouse_y_q;

  logic l_rise;
  logic r_rise;
  logic slot_hit;
  logic [11:0] mx;
  logic [11:0] my;

  logic [9:0]  aim_x [N_TGT];
  logic [9:0]  aim_y [N_TGT];
  logic [11:0] bx_min [N_TGT];
  logic [11:0] bx_max [N_TGT];
  logic [11:0] by_min [N_TGT];
  logic [11:0] by_max [N_TGT];

  for (genvar k = 0; k < N_TGT; k++) begin : g_slot
    assign aim_x[k]  = aim_x_all[k*10 +: 10];
    assign aim_y[k]  = aim_y_all[k*10 +: 10];
    assign bx_min[k] = box_x_min_all[k*12 +: 12];
    assign bx_max[k] = box_x_max_all[k*12 +: 12];
    assign by_min[k] = box_y_min_all[k*12 +: 12];
    assign by_max[k] = box_y_max_all[k*12 +: 12];
  end

  rise_edge_det u_click_l (
    .clk   (clk),
    .rst_n (rst_n),
    .level (click_l),
    .rise  (l_rise)
  );

  rise_edge_det u_click_r (
    .clk   (clk),
    .rst_n (rst_n),
    .level (click_r),
    .rise  (r_rise)
  );

  assign mx = {2'b00, mouse_x_q};
  assign my = {2'b00, mouse_y_q};

  always_comb begin
    slot_hit = aim_detected_all[scan_q] &&
               (bx_min[scan_q] <= mx) && (mx <= bx_max[scan_q]) &&
               (by_min[scan_q] <= my) && (my <= by_max[scan_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StUnlocked;
      scan_q     <= '0;
      found_q    <= 1'b0;
      cand_q     <= '0;
      lost_cnt_q <= '0;
      mouse_x_q  <= '0;
      mouse_y_q  <= '0;
      is_locked  <= 1'b0;
      locked_idx <= '0;
      center_hit <= 1'b0;
      lock_event <= 1'b0;
      lost_event <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lock_event <= 1'b0;
      lost_event <= 1'b0;
      center_hit <= is_locked && aim_detected_all[locked_idx] &&
                    in_center(aim_x[locked_idx], aim_y[locked_idx]);

      if (target_off) begin
        state_q   <= StUnlocked;
        is_locked <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state_q)
          StUnlocked: begin
            if (l_rise) begin
              state_q   <= StSearch;
              busy      <= 1'b1;
              scan_q    <= '0;
              found_q   <= 1'b0;
              mouse_x_q <= mouse_x_pixel;
              mouse_y_q <= mouse_y_pixel;
            end
          end
          StSearch: begin
            if (r_rise) begin
              state_q <= StUnlocked;
              busy    <= 1'b0;
            end else begin
              if (slot_hit && !found_q) begin
                found_q <= 1'b1;
                cand_q  <= scan_q;
              end
              if (scan_q == LastIdx) begin
                busy <= 1'b0;
                if (found_q || slot_hit) begin
                  // A match on the final slot has not reached cand_q yet.
                  state_q    <= StLocked;
                  is_locked  <= 1'b1;
                  lock_event <= 1'b1;
                  locked_idx <= found_q ? cand_q : scan_q;
                end else begin
                  state_q <= StUnlocked;
                end
              end else begin
                scan_q <= scan_q + 4'd1;
              end
            end
          end
          StLocked: begin
            if (r_rise) begin
              state_q   <= StUnlocked;
              is_locked <= 1'b0;
            end else if (frame_start && !aim_detected_all[locked_idx]) begin
              state_q    <= StLost;
              lost_cnt_q <= '0;
            end
          end
          StLost: begin
            if (r_rise) begin
              state_q   <= StUnlocked;
              is_locked <= 1'b0;
            end else if (frame_start) begin
              if (aim_detected_all[locked_idx]) begin
                state_q    <= StLocked;
                lost_cnt_q <= '0;
              end else if (lost_cnt_q == LastCnt) begin
                state_q    <= StUnlocked;
                is_locked  <= 1'b0;
                lost_event <= 1'b1;
                lost_cnt_q <= '0;
              end else begin
                lost_cnt_q <= lost_cnt_q + CntW'(1);
              end
            end
          end
          default: begin
            state_q   <= StUnlocked;
            is_locked <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
